dmem_unit: RTL and testbench
============================

# dmem_unit

Data-memory stage for the RV32I core. It sits directly downstream of the core's data port and consumes the address, write data, byte mask and write request the core drives every cycle. It returns read data one cycle later and provides byte-masked RAM storage plus two memory-mapped registers: a free-running cycle counter and a `tohost` completion register.

## Interface
Parameters:
- `DEPTH`, 64: RAM size in 32-bit words; must be a power of two.
- `ADDR_W`, 6: word-index width, equal to log2(`DEPTH`).

Ports:
- `clk_in`, input, 1: single clock; all state changes on the rising edge.
- `rst_in`, input, 1: reset, asynchronous and active-low.
- `dmaddr_in`, input, 32: byte address from the core.
- `dmdata_in`, input, 32: write data from the core.
- `dmwr_mask_in`, input, 4: byte-lane enables; bit n enables byte n, which is data bits [8n+7:8n].
- `dmwr_req_in`, input, 1: write request for the current cycle.
- `dmdata_out`, output, 32: registered read data returned to the core.
- `done_out`, output, 1: sticky flag, set by a nonzero write to `tohost`.
- `tohost_out`, output, 32: current `tohost` value.

## Operation
Address decode uses `dmaddr_in[31]`:
- 0 selects RAM.
  - Word index is `dmaddr_in[ADDR_W+1:2]`.
  - Bits [1:0] and the upper bits are ignored, so addresses alias modulo `DEPTH`×4.
- 1 selects MMIO, decoded on `dmaddr_in[3:2]`; the other bits are ignored.
  - Index 0 (0x8000_0000): `CYCLE`, read-only; writes are ignored.
  - Index 1 (0x8000_0004): `TOHOST`, read/write.
  - Indices 2 and 3 read 0; writes to them are ignored.

RAM write:
- Occurs when `dmwr_req_in`=1.
- Each byte lane with its mask bit set takes the corresponding byte of `dmdata_in`; the other lanes keep their contents.
- Mask 4'b0000 with a request is a no-op write.

TOHOST write:
- Same per-lane merge as RAM writes.
- If the merged value is nonzero, `done_out` is set and stays set until reset.
- A later write of zero clears `tohost_out` but not `done_out`.

Read behaviour:
- A read is performed every cycle for the presented address; there is no read request.
- When a write and a read target the same location in the same cycle, the read is write-first: next cycle's `dmdata_out` is the merged new word.

CYCLE counter:
- Increments by 1 every cycle after reset is released.
- Wraps from 0xFFFF_FFFF to 0.
- A read returns the value before that cycle's increment.

## Timing
- Read latency: 1 cycle. The address presented in cycle N gives `dmdata_out` valid after edge N+1 and held until the next edge.
- Write: takes effect at the edge ending the request cycle. A read of the same address in cycle N+1 sees the new data at N+2.
- Back-to-back writes and reads are allowed every cycle, with no stalls and no backpressure.
- Reset (`rst_in`=0): immediately, without waiting for a clock edge:
  - `dmdata_out`=0, `CYCLE`=0, `TOHOST`=0, `done_out`=0.
  - RAM contents are not reset.
- Reset asserted mid-write: the write in that cycle is dropped; the RAM keeps its old value for that word.
- First edge after reset release: `CYCLE` becomes 1. A `CYCLE` read presented in that first cycle returns 0.

## Structure
- Shared package `dmem_pkg` holds:
  - `MMIO_BASE`=32'h8000_0000;
  - `MMIO_CYCLE_IDX`=2'd0;
  - `MMIO_TOHOST_IDX`=2'd1;
  - default `DEPTH`/`ADDR_W`;
  - a byte-merge helper function taking old word, new word and mask.
- One sub-module: `dmem_bytelane_ram`.
  - Storage array with four byte-write enables.
  - Synchronous write-first read port.
  - No reset on the array.
- Top level contains only decode, MMIO registers, counter and the output mux/register.

## Test plan
- Reset: hold `rst_in`=0 for 2 cycles → `dmdata_out`=0, `done_out`=0 and `tohost_out`=0, asynchronously and before any clock edge.
- Full-word RAM write/read:
  - Write 0xDEADBEEF to 0x0000_0010 with mask 4'hF.
  - Read 0x10 → 0xDEADBEEF one cycle after the address.
  - Read 0x110 (alias when `DEPTH`=64) → same value.
- Byte-mask merge:
  - Preload 0x11223344 at 0x20.
  - Write 0xAABBCCDD with mask 4'b0101 → read 0x11BB33DD.
  - Then write with mask 0 → value unchanged.
- Write-first on the same address: in one cycle write 0x12345678 to 0x8 and read 0x8 → next `dmdata_out`=0x12345678, not the old value.
- CYCLE counter:
  - Release reset, read 0x8000_0000 every cycle → 0,1,2,… with no gaps.
  - Force the counter to 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0.
  - A write to `CYCLE` is ignored.
- TOHOST:
  - Write 0x1 with mask 4'hF to 0x8000_0004 → `done_out`=1 and `tohost_out`=1 after the edge.
  - Write 0 → `tohost_out`=0 and `done_out` stays 1.
  - Read 0x8000_0008 → 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory stage.
package dmem_pkg;
    localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
    localparam logic [1:0]  MMIO_CYCLE_IDX  = 2'd0;
    localparam logic [1:0]  MMIO_TOHOST_IDX = 2'd1;
    localparam int          DMEM_DEPTH      = 64;
    localparam int          DMEM_ADDR_W     = 6;

    // Lane n of the result comes from new_word when mask[n] is set, else from old_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int n = 0; n < 4; n++)
            res[8*n +: 8] = mask[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
        return res;
    endfunction
endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word RAM with per-byte write enables and a registered write-first read port.
module dmem_bytelane_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] merged;

    assign merged = byte_merge(mem[addr], wdata, be);

    always_ff @(posedge clk_in) begin
        if (we)
            mem[addr] <= merged;
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            rdata <= '0;
        else
            rdata <= we ? merged : mem[addr];
    end
endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: RAM, CYCLE counter and TOHOST register behind a one-cycle read port.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic        dmwr_req_in,
    output logic [31:0] dmdata_out,
    output logic        done_out,
    output logic [31:0] tohost_out
);
    logic        is_mmio;
    logic [1:0]  mmio_idx;
    logic        ram_we;
    logic        tohost_we;
    logic [31:0] tohost_next;
    logic [31:0] mmio_rd;
    logic [31:0] ram_rd;
    logic [31:0] cycle_q;
    logic [31:0] tohost_q;
    logic [31:0] mmio_rd_q;
    logic        src_mmio_q;
    logic        unused_addr;

    assign is_mmio     = dmaddr_in[31];
    assign mmio_idx    = dmaddr_in[3:2];
    // Gating with reset drops a write whose edge arrives while reset is held.
    assign ram_we      = dmwr_req_in & ~is_mmio & rst_in;
    assign tohost_we   = dmwr_req_in & is_mmio & (mmio_idx == MMIO_TOHOST_IDX);
    assign tohost_next = byte_merge(tohost_q, dmdata_in, dmwr_mask_in);
    assign unused_addr = ^{dmaddr_in[30:ADDR_W+2], dmaddr_in[1:0]};

    dmem_bytelane_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .addr   (dmaddr_in[ADDR_W+1:2]),
        .we     (ram_we),
        .be     (dmwr_mask_in),
        .wdata  (dmdata_in),
        .rdata  (ram_rd)
    );

    always_comb begin
        mmio_rd = '0;
        case (mmio_idx)
            MMIO_CYCLE_IDX:  mmio_rd = cycle_q;
            MMIO_TOHOST_IDX: mmio_rd = tohost_we ? tohost_next : tohost_q;
            default:         mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_q    <= '0;
            tohost_q   <= '0;
            done_out   <= 1'b0;
            mmio_rd_q  <= '0;
            src_mmio_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_q + 32'd1;
            mmio_rd_q  <= mmio_rd;
            src_mmio_q <= is_mmio;
            if (tohost_we) begin
                tohost_q <= tohost_next;
                if (tohost_next != '0)
                    done_out <= 1'b1;
            end
        end
    end

    assign dmdata_out = src_mmio_q ? mmio_rd_q : ram_rd;
    assign tohost_out = tohost_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: directed and random traffic against a byte-level memory model.
module tb_dmem_unit;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] dmaddr_in;
    logic [31:0] dmdata_in;
    logic [3:0]  dmwr_mask_in;
    logic        dmwr_req_in;
    logic [31:0] dmdata_out;
    logic        done_out;
    logic [31:0] tohost_out;

    dmem_unit #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .dmaddr_in    (dmaddr_in),
        .dmdata_in    (dmdata_in),
        .dmwr_mask_in (dmwr_mask_in),
        .dmwr_req_in  (dmwr_req_in),
        .dmdata_out   (dmdata_out),
        .done_out     (done_out),
        .tohost_out   (tohost_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        logic        done;
        logic [31:0] tohost;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: bytes of each word, with a flag for bytes ever written.
    logic [7:0]  m_byte [64][4];
    bit          m_known[64][4];
    logic [31:0] m_cycle;
    logic [31:0] m_tohost;
    logic        m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: the read for each issued cycle appears just after the following rising edge.
    always @(posedge clk_in) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk_data) check({e.name, ".data"}, dmdata_out, e.data);
            check({e.name, ".done"}, {31'd0, done_out}, {31'd0, e.done});
            check({e.name, ".tohost"}, tohost_out, e.tohost);
        end
    end

    // Drives one cycle of traffic (called just after a falling edge) and predicts its outcome.
    task automatic do_cycle(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic req);
        exp_t e;
        int   w;
        logic [31:0] rd;
        bit   all_known;
        dmaddr_in    = addr;
        dmdata_in    = data;
        dmwr_mask_in = mask;
        dmwr_req_in  = req;
        rd = '0;
        all_known = 1'b1;
        if (addr[31] == 1'b0) begin
            w = int'(addr[7:2]);
            for (int b = 0; b < 4; b++) begin
                if (req && mask[b]) begin
                    m_byte[w][b]  = data[8*b +: 8];
                    m_known[w][b] = 1'b1;
                end
                rd[8*b +: 8] = m_byte[w][b];
                if (!m_known[w][b]) all_known = 1'b0;
            end
        end else begin
            case (addr[3:2])
                2'd0: rd = m_cycle;
                2'd1: begin
                    if (req)
                        for (int b = 0; b < 4; b++)
                            if (mask[b]) m_tohost[8*b +: 8] = data[8*b +: 8];
                    if (req && m_tohost != 0) m_done = 1'b1;
                    rd = m_tohost;
                end
                default: rd = '0;
            endcase
        end
        m_cycle      = m_cycle + 1;
        e.data       = rd;
        e.chk_data   = all_known;
        e.done       = m_done;
        e.tohost     = m_tohost;
        e.name       = name;
        exp_q.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic model_reset();
        m_cycle  = '0;
        m_tohost = '0;
        m_done   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 4; b++) m_known[i][b] = 1'b0;
        model_reset();
        rst_in = 1'b0;
        dmaddr_in = '0; dmdata_in = '0; dmwr_mask_in = '0; dmwr_req_in = 1'b0;
        #1;
        check("rst_async.data", dmdata_out, 32'h0);
        check("rst_async.done", {31'd0, done_out}, 32'h0);
        check("rst_async.tohost", tohost_out, 32'h0);
        repeat (2) @(negedge clk_in);
        check("rst_held.data", dmdata_out, 32'h0);
        check("rst_held.done", {31'd0, done_out}, 32'h0);
        rst_in = 1'b1;

        for (int i = 0; i < 6; i++) do_cycle("cycle_run", MMIO_ADDR(0), 32'h0, 4'h0, 1'b0);
        do_cycle("cycle_wr", MMIO_ADDR(0), 32'h5555_5555, 4'hF, 1'b1);
        do_cycle("cycle_after_wr", MMIO_ADDR(0), 32'h0, 4'h0, 1'b0);

        do_cycle("wr_deadbeef", 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        do_cycle("rd_0x10", 32'h0000_0010, 32'h0, 4'h0, 1'b0);
        do_cycle("rd_alias_0x110", 32'h0000_0110, 32'h0, 4'h0, 1'b0);

        do_cycle("preload_0x20", 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1);
        do_cycle("merge_0101", 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1);
        do_cycle("rd_merged", 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        do_cycle("mask0_wr", 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1);
        do_cycle("rd_after_mask0", 32'h0000_0020, 32'h0, 4'h0, 1'b0);

        do_cycle("preload_0x8", 32'h0000_0008, 32'hCAFE_0000, 4'hF, 1'b1);
        do_cycle("rd_old_0x8", 32'h0000_0008, 32'h0, 4'h0, 1'b0);
        do_cycle("wfirst_0x8", 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b1);

        do_cycle("tohost_wr1", MMIO_ADDR(1), 32'h0000_0001, 4'hF, 1'b1);
        do_cycle("tohost_rd", MMIO_ADDR(1), 32'h0, 4'h0, 1'b0);
        do_cycle("tohost_wr0", MMIO_ADDR(1), 32'h0000_0000, 4'hF, 1'b1);
        do_cycle("mmio2_wr", MMIO_ADDR(2), 32'hFFFF_FFFF, 4'hF, 1'b1);
        do_cycle("mmio2_rd", MMIO_ADDR(2), 32'h0, 4'h0, 1'b0);
        do_cycle("mmio3_rd", MMIO_ADDR(3), 32'h0, 4'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 7);
            if (sel < 6) a = $urandom & 32'h7FFF_FFFF;
            else         a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
            do_cycle("random", a, $urandom, 4'($urandom), 1'($urandom));
        end

        do_cycle("preload_0x30", 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 1'b1);
        rst_in       = 1'b0;
        dmaddr_in    = 32'h0000_0030;
        dmdata_in    = 32'h7777_7777;
        dmwr_mask_in = 4'hF;
        dmwr_req_in  = 1'b1;
        #1;
        check("rst_mid.data", dmdata_out, 32'h0);
        check("rst_mid.done", {31'd0, done_out}, 32'h0);
        check("rst_mid.tohost", tohost_out, 32'h0);
        @(negedge clk_in);
        model_reset();
        rst_in = 1'b1;
        do_cycle("rd_after_rst_0x30", 32'h0000_0030, 32'h0, 4'h0, 1'b0);
        do_cycle("cycle_after_rst", MMIO_ADDR(0), 32'h0, 4'h0, 1'b0);

        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) do_cycle("cycle_wrap", MMIO_ADDR(0), 32'h0, 4'h0, 1'b0);

        repeat (2) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic logic [31:0] MMIO_ADDR(input int idx);
        return 32'h8000_0000 + 32'(idx * 4);
    endfunction
endmodule
